// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the LEGv8 pipeline hazard controller.
// Holds FSM encodings, the zero register index and the control bundle.
package hazard_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t RUN      = 2'd0;
  localparam state_t MEM_WAIT = 2'd1;
  localparam state_t HALT     = 2'd2;

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic pc_stall;
    logic id_bubble;
    logic if_flush;
    logic ex_flush;
    logic ex_stall;
    logic mem_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE   = 6'b000000;
  localparam ctrl_t CTRL_LU     = 6'b110000;
  localparam ctrl_t CTRL_FLUSH  = 6'b011100;
  localparam ctrl_t CTRL_FREEZE = 6'b100011;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// master drives the hazard inputs, slave is the controller side.
interface hazard_control_unit_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rn_ID;
  logic [4:0]       rm_ID;
  logic             rn_used_ID;
  logic             rm_used_ID;
  logic             MemRead_EX;
  logic [4:0]       RD_EX;
  logic             branch_taken_MEM;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_stall;
  logic             id_bubble;
  logic             if_flush;
  logic             ex_flush;
  logic             ex_stall;
  logic             mem_bubble;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output rn_ID, rm_ID, rn_used_ID, rm_used_ID,
    output MemRead_EX, RD_EX, branch_taken_MEM,
    output dmem_req, dmem_ready,
    input  pc_stall, id_bubble, if_flush, ex_flush,
    input  ex_stall, mem_bubble, mem_timeout,
    input  stall_cycles, flush_events
  );

  modport slave (
    input  rn_ID, rm_ID, rn_used_ID, rm_used_ID,
    input  MemRead_EX, RD_EX, branch_taken_MEM,
    input  dmem_req, dmem_ready,
    output pc_stall, id_bubble, if_flush, ex_flush,
    output ex_stall, mem_bubble, mem_timeout,
    output stall_cycles, flush_events
  );

endinterface

// File: rtl/hazard_control_unit_load_use_detect.sv
// Combinational load-use compare between the EX load and ID sources.
// A load targeting XZR never creates a dependency.
module load_use_detect
  import hazard_ctrl_pkg::*;
(
  input  logic       i_mem_read_ex,
  input  logic [4:0] i_rd_ex,
  input  logic [4:0] i_rn_id,
  input  logic [4:0] i_rm_id,
  input  logic       i_rn_used,
  input  logic       i_rm_used,
  output logic       o_lu
);

  logic w_rn_hit;
  logic w_rm_hit;

  assign w_rn_hit = i_rn_used & (i_rn_id == i_rd_ex);
  assign w_rm_hit = i_rm_used & (i_rm_id == i_rd_ex);

  assign o_lu = i_mem_read_ex & (i_rd_ex != XZR)
              & (w_rn_hit | w_rm_hit);

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls, branch squashes,
// data-memory freezes with a watchdog, and saturating perf counters.
module hazard_control_unit
  import hazard_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32,
  parameter int WAIT_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rn_ID,
  input  logic [4:0]       rm_ID,
  input  logic             rn_used_ID,
  input  logic             rm_used_ID,
  input  logic             MemRead_EX,
  input  logic [4:0]       RD_EX,
  input  logic             branch_taken_MEM,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             id_bubble,
  output logic             if_flush,
  output logic             ex_flush,
  output logic             ex_stall,
  output logic             mem_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  state_t            w_state_nxt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              w_timeout_nxt;
  logic              w_lu;
  logic              w_flush_evt;
  ctrl_t             w_run_ctrl;
  ctrl_t             w_ctrl;

  load_use_detect u_lu (
    .i_mem_read_ex (MemRead_EX),
    .i_rd_ex       (RD_EX),
    .i_rn_id       (rn_ID),
    .i_rm_id       (rm_ID),
    .i_rn_used     (rn_used_ID),
    .i_rm_used     (rm_used_ID),
    .o_lu          (w_lu)
  );

  // Branch squash wins over load-use: the ID instruction is discarded.
  always_comb begin
    w_run_ctrl = CTRL_NONE;
    if (branch_taken_MEM) begin
      w_run_ctrl = CTRL_FLUSH;
    end else if (w_lu) begin
      w_run_ctrl = CTRL_LU;
    end
  end

  always_comb begin
    w_ctrl        = CTRL_NONE;
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait_cnt;
    w_timeout_nxt = r_timeout;
    w_flush_evt   = 1'b0;
    if (reset) begin
      w_ctrl = CTRL_FLUSH;
    end else begin
      unique case (r_state)
        HALT: begin
          w_ctrl = CTRL_FREEZE;
        end
        MEM_WAIT: begin
          if (!dmem_ready) begin
            w_ctrl = CTRL_FREEZE;
            if (r_wait_cnt == WAIT_W'(MAX_WAIT)) begin
              w_state_nxt   = HALT;
              w_timeout_nxt = 1'b1;
            end else begin
              w_wait_nxt = r_wait_cnt + 1'b1;
            end
          end else begin
            w_ctrl      = w_run_ctrl;
            w_flush_evt = branch_taken_MEM;
            w_state_nxt = RUN;
            w_wait_nxt  = '0;
          end
        end
        default: begin
          if (dmem_req && !dmem_ready) begin
            w_ctrl      = CTRL_FREEZE;
            w_state_nxt = MEM_WAIT;
            w_wait_nxt  = WAIT_W'(1);
          end else begin
            w_ctrl      = w_run_ctrl;
            w_flush_evt = branch_taken_MEM;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_timeout  <= w_timeout_nxt;
      if (w_ctrl.pc_stall && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flush_evt && !(&r_flush_cnt)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign pc_stall     = w_ctrl.pc_stall;
  assign id_bubble    = w_ctrl.id_bubble;
  assign if_flush     = w_ctrl.if_flush;
  assign ex_flush     = w_ctrl.ex_flush;
  assign ex_stall     = w_ctrl.ex_stall;
  assign mem_bubble   = w_ctrl.mem_bubble;
  assign mem_timeout  = r_timeout;
  assign stall_cycles = r_stall_cnt;
  assign flush_events = r_flush_cnt;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the control rules.
module tb_hazard_control_unit;

  localparam int CNT_W    = 32;
  localparam int MAX_WAIT = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_control_unit_if #(.CNT_W(CNT_W)) hif ();

  hazard_control_unit #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W),
    .WAIT_W   (5)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .rn_ID            (hif.rn_ID),
    .rm_ID            (hif.rm_ID),
    .rn_used_ID       (hif.rn_used_ID),
    .rm_used_ID       (hif.rm_used_ID),
    .MemRead_EX       (hif.MemRead_EX),
    .RD_EX            (hif.RD_EX),
    .branch_taken_MEM (hif.branch_taken_MEM),
    .dmem_req         (hif.dmem_req),
    .dmem_ready       (hif.dmem_ready),
    .pc_stall         (hif.pc_stall),
    .id_bubble        (hif.id_bubble),
    .if_flush         (hif.if_flush),
    .ex_flush         (hif.ex_flush),
    .ex_stall         (hif.ex_stall),
    .mem_bubble       (hif.mem_bubble),
    .mem_timeout      (hif.mem_timeout),
    .stall_cycles     (hif.stall_cycles),
    .flush_events     (hif.flush_events)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: which phase the pipeline is in and what has been counted.
  bit          m_known   = 1'b0;
  bit          m_waiting = 1'b0;
  bit          m_halted  = 1'b0;
  int          m_waited  = 0;
  bit          m_to      = 1'b0;
  logic [31:0] m_stalls  = '0;
  logic [31:0] m_flushes = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic bit load_use();
    bit dep;
    dep = (hif.rn_used_ID && hif.rn_ID == hif.RD_EX) ||
          (hif.rm_used_ID && hif.rm_ID == hif.RD_EX);
    return hif.MemRead_EX && hif.RD_EX != 5'd31 && dep;
  endfunction

  function automatic bit frozen();
    if (m_halted) return 1'b1;
    if (m_waiting) return !hif.dmem_ready;
    return hif.dmem_req && !hif.dmem_ready;
  endfunction

  task automatic check_model();
    bit fz, br, lu;
    bit e_pcs, e_idb, e_iff, e_exf, e_exs, e_mb;
    fz = frozen();
    br = hif.branch_taken_MEM;
    lu = load_use();
    if (reset) begin
      e_pcs = 0; e_idb = 1; e_iff = 1; e_exf = 1; e_exs = 0; e_mb = 0;
    end else if (fz) begin
      e_pcs = 1; e_idb = 0; e_iff = 0; e_exf = 0; e_exs = 1; e_mb = 1;
    end else begin
      e_pcs = !br && lu;
      e_idb = br || lu;
      e_iff = br;
      e_exf = br;
      e_exs = 0;
      e_mb  = 0;
    end
    chk("pc_stall", hif.pc_stall, e_pcs);
    chk("id_bubble", hif.id_bubble, e_idb);
    chk("if_flush", hif.if_flush, e_iff);
    chk("ex_flush", hif.ex_flush, e_exf);
    chk("ex_stall", hif.ex_stall, e_exs);
    chk("mem_bubble", hif.mem_bubble, e_mb);
    if (m_known) begin
      chk("mem_timeout", hif.mem_timeout, m_to);
      chk("stall_cycles", hif.stall_cycles, m_stalls);
      chk("flush_events", hif.flush_events, m_flushes);
    end
  endtask

  task automatic model_update();
    bit fz, br, lu;
    fz = frozen();
    br = hif.branch_taken_MEM;
    lu = load_use();
    if (reset) begin
      m_known   = 1'b1;
      m_waiting = 1'b0;
      m_halted  = 1'b0;
      m_waited  = 0;
      m_to      = 1'b0;
      m_stalls  = '0;
      m_flushes = '0;
    end else begin
      if (fz || (!br && lu)) begin
        if (m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
      end
      if (!fz && br) begin
        if (m_flushes != 32'hFFFF_FFFF) m_flushes = m_flushes + 1;
      end
      if (m_halted) begin
        m_halted = 1'b1;
      end else if (fz) begin
        m_waited = m_waited + 1;
        m_waiting = 1'b1;
        if (m_waited > MAX_WAIT) begin
          m_halted = 1'b1;
          m_to     = 1'b1;
        end
      end else begin
        m_waiting = 1'b0;
        m_waited  = 0;
      end
    end
  endtask

  task automatic pre();
    @(negedge clk);
    #1;
    check_model();
  endtask

  task automatic post();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick();
    pre();
    post();
  endtask

  task automatic idle();
    hif.rn_ID            = 5'd0;
    hif.rm_ID            = 5'd0;
    hif.rn_used_ID       = 1'b0;
    hif.rm_used_ID       = 1'b0;
    hif.MemRead_EX       = 1'b0;
    hif.RD_EX            = 5'd0;
    hif.branch_taken_MEM = 1'b0;
    hif.dmem_req         = 1'b0;
    hif.dmem_ready       = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [4:0] pick_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    idle();
    reset = 1'b1;
    tick();
    pre();
    chk("rst_if_flush", hif.if_flush, 1);
    chk("rst_ex_flush", hif.ex_flush, 1);
    post();
    reset = 1'b0;
    pre();
    chk("rst_stall_cycles", hif.stall_cycles, 0);
    chk("rst_idle_pc_stall", hif.pc_stall, 0);
    post();

    hif.MemRead_EX = 1; hif.RD_EX = 5'd9;
    hif.rn_ID = 5'd9; hif.rn_used_ID = 1;
    pre();
    chk("lu_pc_stall", hif.pc_stall, 1);
    chk("lu_id_bubble", hif.id_bubble, 1);
    post();
    hif.MemRead_EX = 0;
    pre();
    chk("lu_one_cycle", hif.pc_stall, 0);
    chk("lu_stall_cnt", hif.stall_cycles, 1);
    post();
    hif.MemRead_EX = 1; hif.RD_EX = 5'd31; hif.rn_ID = 5'd31;
    pre();
    chk("xzr_no_stall", hif.pc_stall, 0);
    post();

    idle();
    hif.MemRead_EX = 1; hif.RD_EX = 5'd4;
    hif.rm_ID = 5'd4; hif.rm_used_ID = 1;
    hif.branch_taken_MEM = 1;
    pre();
    chk("br_if_flush", hif.if_flush, 1);
    chk("br_ex_flush", hif.ex_flush, 1);
    chk("br_pc_stall", hif.pc_stall, 0);
    post();
    idle();
    pre();
    chk("br_flush_cnt", hif.flush_events, 1);
    chk("br_stall_cnt", hif.stall_cycles, 1);
    post();

    do_reset();
    hif.dmem_req = 1; hif.dmem_ready = 0;
    repeat (3) begin
      pre();
      chk("wait_pc_stall", hif.pc_stall, 1);
      chk("wait_mem_bubble", hif.mem_bubble, 1);
      post();
    end
    hif.dmem_ready = 1;
    pre();
    chk("ready_pc_stall", hif.pc_stall, 0);
    chk("ready_ex_stall", hif.ex_stall, 0);
    post();
    idle();
    pre();
    chk("wait_stall_cnt", hif.stall_cycles, 3);
    post();

    do_reset();
    hif.dmem_req = 1; hif.dmem_ready = 0; hif.branch_taken_MEM = 1;
    repeat (2) begin
      pre();
      chk("wait_br_no_flush", hif.if_flush, 0);
      post();
    end
    hif.dmem_ready = 1;
    pre();
    chk("wait_br_flush", hif.if_flush, 1);
    chk("wait_br_pc_stall", hif.pc_stall, 0);
    post();
    idle();
    pre();
    chk("wait_br_flush_cnt", hif.flush_events, 1);
    post();

    do_reset();
    hif.dmem_req = 1; hif.dmem_ready = 0;
    repeat (17) begin
      pre();
      chk("wd_not_yet", hif.mem_timeout, 0);
      post();
    end
    pre();
    chk("wd_timeout", hif.mem_timeout, 1);
    post();
    idle();
    repeat (3) begin
      pre();
      chk("halt_pc_stall", hif.pc_stall, 1);
      chk("halt_ex_stall", hif.ex_stall, 1);
      post();
    end
    do_reset();
    pre();
    chk("post_halt_pc_stall", hif.pc_stall, 0);
    chk("post_halt_if_flush", hif.if_flush, 0);
    chk("post_halt_timeout", hif.mem_timeout, 0);
    post();

    hif.dmem_req = 1; hif.dmem_ready = 0;
    tick();
    tick();
    reset = 1'b1;
    pre();
    chk("midrst_if_flush", hif.if_flush, 1);
    chk("midrst_pc_stall", hif.pc_stall, 0);
    post();
    reset = 1'b0;
    idle();
    pre();
    chk("midrst_stall_cnt", hif.stall_cycles, 0);
    chk("midrst_run", hif.pc_stall, 0);
    post();

    for (int i = 0; i < 4000; i++) begin
      reset                = ($urandom_range(0, 199) == 0);
      hif.rn_ID            = pick_reg();
      hif.rm_ID            = pick_reg();
      hif.RD_EX            = pick_reg();
      hif.rn_used_ID       = 1'($urandom_range(0, 1));
      hif.rm_used_ID       = 1'($urandom_range(0, 1));
      hif.MemRead_EX       = 1'($urandom_range(0, 1));
      hif.branch_taken_MEM = ($urandom_range(0, 7) == 0);
      hif.dmem_req         = ($urandom_range(0, 2) == 0);
      if (i < 2000)
        hif.dmem_ready = ($urandom_range(0, 3) != 0);
      else
        hif.dmem_ready = ($urandom_range(0, 24) == 0);
      tick();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
